// File: rtl/ion_stream_scheduler.sv
// ion_stream_scheduler: captures 110-bit packets from eight sensor streams,
// picks among pending streams round-robin and serialises the chosen packet
// as one header byte followed by fourteen payload bytes over valid/ready.
module ion_stream_scheduler #(
    parameter logic [4:0] HEADER_TAG    = 5'b10100,
    parameter int         PAYLOAD_BYTES = 14
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         capture,
    input  logic [7:0]   ready_in,
    input  logic [109:0] data_in0,
    input  logic [109:0] data_in1,
    input  logic [109:0] data_in2,
    input  logic [109:0] data_in3,
    input  logic [109:0] data_in4,
    input  logic [109:0] data_in5,
    input  logic [109:0] data_in6,
    input  logic [109:0] data_in7,
    input  logic         clear_overflow,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    output logic         busy,
    output logic [2:0]   current_stream,
    output logic [7:0]   pending,
    output logic [7:0]   overflow,
    output logic         packet_done
);

    localparam logic [3:0] LAST_BYTE = 4'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [109:0]   data_bus [8];
    logic [109:0]   hold [8];
    logic [109:0]   shift;
    logic [3:0]     byte_cnt;
    logic [2:0]     rr_ptr;
    logic [2:0]     grant;
    logic [2:0]     probe;
    logic           grant_valid;
    logic           take;
    logic           handshake;
    logic [7:0]     captured;
    logic [7:0]     granted;
    logic [7:0]     overflow_set;
    logic [7:0]     pending_next;
    logic [7:0]     overflow_next;

    assign data_bus[0] = data_in0;
    assign data_bus[1] = data_in1;
    assign data_bus[2] = data_in2;
    assign data_bus[3] = data_in3;
    assign data_bus[4] = data_in4;
    assign data_bus[5] = data_in5;
    assign data_bus[6] = data_in6;
    assign data_bus[7] = data_in7;

    // Find the first pending stream at or after rr_ptr, wrapping modulo 8.
    always_comb begin
        grant       = 3'd0;
        grant_valid = 1'b0;
        probe       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            probe = rr_ptr + 3'(i);
            if (pending[probe]) begin
                grant       = probe;
                grant_valid = 1'b1;
            end
        end
    end

    assign take      = (state == IDLE) && grant_valid;
    assign handshake = tx_valid && tx_ready;

    // A capture re-arms pending even on the grant edge, so back-to-back
    // packets on one stream are both sent and do not count as an overwrite.
    assign captured      = capture ? ready_in : 8'h00;
    assign granted       = take ? (8'h01 << grant) : 8'h00;
    assign overflow_set  = captured & pending & ~granted;
    assign pending_next  = captured | (pending & ~granted);
    assign overflow_next = (clear_overflow ? 8'h00 : overflow) | overflow_set;

    // State register for the serialiser.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and byte-interface outputs; tx_data only moves on a handshake.
    always_comb begin
        state_next  = state;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        busy        = 1'b1;
        packet_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_valid) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                tx_valid = 1'b1;
                tx_data  = {HEADER_TAG, current_stream};
                if (tx_ready) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_valid = 1'b1;
                if (byte_cnt == LAST_BYTE) begin
                    tx_data = {shift[109:104], 2'b00};
                    if (tx_ready) begin
                        state_next = DONE;
                    end
                end else begin
                    tx_data = shift[109:102];
                end
            end
            DONE: begin
                packet_done = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: grant loading, payload shifting, capture holding and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr         <= 3'd0;
            current_stream <= 3'd0;
            byte_cnt       <= 4'd0;
            shift          <= '0;
            pending        <= 8'h00;
            overflow       <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                hold[k] <= '0;
            end
        end else begin
            if (take) begin
                current_stream <= grant;
                shift          <= hold[grant];
                rr_ptr         <= grant + 3'd1;
            end else if ((state == PAYLOAD) && handshake) begin
                shift    <= {shift[101:0], 8'h00};
                byte_cnt <= byte_cnt + 4'd1;
            end
            if ((state == HEADER) && handshake) begin
                byte_cnt <= 4'd0;
            end
            for (int k = 0; k < 8; k++) begin
                if (captured[k]) begin
                    hold[k] <= data_bus[k];
                end
            end
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_ion_stream_scheduler.sv
// Testbench for ion_stream_scheduler: a packet-level reference model
// (pending flags, held packets and a queue of bytes still owed to the
// transmitter) is compared to the DUT every cycle, and directed scenarios
// add hand-computed byte and flag expectations.
module tb_ion_stream_scheduler;

    logic         clock;
    logic         reset;
    logic         capture;
    logic [7:0]   ready_in;
    logic [109:0] din [8];
    logic         clear_overflow;
    logic         tx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         busy;
    logic [2:0]   current_stream;
    logic [7:0]   pending;
    logic [7:0]   overflow;
    logic         packet_done;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int done_before;
    logic [7:0] tx_log [$];

    // Reference model state
    logic [7:0]   m_pend;
    logic [7:0]   m_ovf;
    logic [2:0]   m_rr;
    logic [2:0]   m_cur;
    logic         m_done;
    logic [109:0] m_hold [8];
    logic [7:0]   m_bytes [$];
    int           m_g;
    logic         m_last;
    logic [7:0]   m_set;
    logic [111:0] m_padded;

    ion_stream_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .capture        (capture),
        .ready_in       (ready_in),
        .data_in0       (din[0]),
        .data_in1       (din[1]),
        .data_in2       (din[2]),
        .data_in3       (din[3]),
        .data_in4       (din[4]),
        .data_in5       (din[5]),
        .data_in6       (din[6]),
        .data_in7       (din[7]),
        .clear_overflow (clear_overflow),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .busy           (busy),
        .current_stream (current_stream),
        .pending        (pending),
        .overflow       (overflow),
        .packet_done    (packet_done)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkLog(input string name, input int idx, input logic [7:0] exp);
        logic [7:0] act;
        act = (idx < tx_log.size()) ? tx_log[idx] : 8'hxx;
        checkOutput(name, act, exp);
    endtask

    // Packet whose data is 110'h1: header, thirteen zero bytes, then 04.
    task automatic checkUnitPacket(input string name, input int base, input logic [7:0] hdr);
        checkLog({name, "_hdr"}, base, hdr);
        for (int i = 1; i <= 13; i++) begin
            checkLog({name, "_mid"}, base + i, 8'h00);
        end
        checkLog({name, "_tail"}, base + 14, 8'h04);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One capture cycle for the streams in rdy, using the current din values.
    task automatic applyStimulus(input logic [7:0] rdy);
        capture  = 1'b1;
        ready_in = rdy;
        tick();
        capture  = 1'b0;
        ready_in = 8'h00;
    endtask

    task automatic doReset();
        reset          = 1'b1;
        capture        = 1'b0;
        ready_in       = 8'h00;
        clear_overflow = 1'b0;
        tx_ready       = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tx_log.delete();
    endtask

    task automatic waitDone(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (packet_done === 1'b1) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, {7'b0, seen}, 8'h01);
        tick();
    endtask

    // Reference model: advance one clock edge at the packet/byte level.
    always @(posedge clock) begin
        if (reset) begin
            m_pend = 8'h00;
            m_ovf  = 8'h00;
            m_rr   = 3'd0;
            m_cur  = 3'd0;
            m_done = 1'b0;
            m_bytes.delete();
            for (int k = 0; k < 8; k++) m_hold[k] = '0;
        end else begin
            m_g    = -1;
            m_last = 1'b0;
            if (m_bytes.size() == 0 && !m_done && m_pend != 8'h00) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_g < 0 && m_pend[(int'(m_rr) + i) % 8]) m_g = (int'(m_rr) + i) % 8;
                end
                m_padded = {m_hold[m_g], 2'b00};
                m_bytes.push_back({5'b10100, 3'(m_g)});
                for (int b = 0; b < 14; b++) m_bytes.push_back(m_padded[111 - 8*b -: 8]);
                m_cur = 3'(m_g);
                m_rr  = 3'((m_g + 1) % 8);
            end else if (m_bytes.size() > 0 && tx_ready) begin
                void'(m_bytes.pop_front());
                if (m_bytes.size() == 0) m_last = 1'b1;
            end
            m_done = m_last;
            m_set  = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (capture && ready_in[k]) begin
                    if (m_pend[k] && m_g != k) m_set[k] = 1'b1;
                    m_hold[k] = din[k];
                    m_pend[k] = 1'b1;
                end else if (m_g == k) begin
                    m_pend[k] = 1'b0;
                end
            end
            m_ovf = (clear_overflow ? 8'h00 : m_ovf) | m_set;
        end
    end

    // Compare DUT against the model every cycle and log accepted bytes.
    always @(negedge clock) begin
        checkOutput("tx_valid", {7'b0, tx_valid}, {7'b0, (m_bytes.size() > 0)});
        if (m_bytes.size() > 0) checkOutput("tx_data", tx_data, m_bytes[0]);
        checkOutput("busy", {7'b0, busy}, {7'b0, (m_bytes.size() > 0) || m_done});
        checkOutput("packet_done", {7'b0, packet_done}, {7'b0, m_done});
        checkOutput("pending", pending, m_pend);
        checkOutput("overflow", overflow, m_ovf);
        checkOutput("current_stream", {5'b0, current_stream}, {5'b0, m_cur});
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_log.push_back(tx_data);
        if (packet_done === 1'b1) done_count++;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios
    initial begin
        for (int k = 0; k < 8; k++) din[k] = '0;
        reset = 1'b1;
        capture = 1'b0;
        ready_in = 8'h00;
        clear_overflow = 1'b0;
        tx_ready = 1'b1;
        doReset();

        // Reset state
        @(negedge clock);
        checkOutput("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        checkOutput("rst_busy", {7'b0, busy}, 8'h00);
        checkOutput("rst_pending", pending, 8'h00);
        checkOutput("rst_overflow", overflow, 8'h00);
        tick();

        // Single packet on stream 2 with data 1
        $display("[TB] single packet");
        din[2] = 110'h1;
        done_before = done_count;
        applyStimulus(8'h04);
        @(negedge clock);
        checkOutput("single_pend_vis", pending, 8'h04);
        checkOutput("single_not_yet_valid", {7'b0, tx_valid}, 8'h00);
        @(negedge clock);
        checkOutput("single_hdr_valid", {7'b0, tx_valid}, 8'h01);
        checkOutput("single_hdr_data", tx_data, 8'hA2);
        tick();
        waitDone("single", 40);
        checkOutput("single_len", 8'(tx_log.size()), 8'd15);
        checkUnitPacket("single", 0, 8'hA2);
        checkOutput("single_done_once", 8'(done_count - done_before), 8'd1);
        checkOutput("single_pend_clr", pending, 8'h00);

        // Round robin 0 then 7, twice
        $display("[TB] round robin");
        doReset();
        din[0] = 110'h1;
        din[7] = 110'h1;
        for (int r = 0; r < 2; r++) begin
            tx_log.delete();
            applyStimulus(8'h81);
            waitDone("rr_first", 40);
            waitDone("rr_second", 40);
            checkUnitPacket("rr_s0", 0, 8'hA0);
            checkUnitPacket("rr_s7", 15, 8'hA7);
        end

        // Backpressure in mid payload
        $display("[TB] backpressure");
        doReset();
        din[2] = 110'h1;
        done_before = done_count;
        applyStimulus(8'h04);
        repeat (4) tick();
        tx_ready = 1'b0;
        repeat (5) tick();
        tx_ready = 1'b1;
        waitDone("stall", 60);
        checkOutput("stall_len", 8'(tx_log.size()), 8'd15);
        checkUnitPacket("stall", 0, 8'hA2);
        checkOutput("stall_done_once", 8'(done_count - done_before), 8'd1);

        // Overflow on stream 5 while stream 3 is sent
        $display("[TB] overflow");
        doReset();
        din[3] = 110'h1;
        applyStimulus(8'h08);
        repeat (3) tick();
        din[5] = 110'h1;
        applyStimulus(8'h20);
        din[5] = {6'h2A, 104'h0};
        applyStimulus(8'h20);
        @(negedge clock);
        checkOutput("ovf_set", overflow, 8'h20);
        checkOutput("ovf_pending", pending, 8'h20);
        tick();
        waitDone("ovf_s3", 40);
        waitDone("ovf_s5", 40);
        checkUnitPacket("ovf_s3", 0, 8'hA3);
        checkLog("ovf_s5_hdr", 15, 8'hA5);
        checkLog("ovf_s5_first", 16, 8'hA8);
        checkLog("ovf_s5_tail", 29, 8'h00);
        checkOutput("ovf_still_set", overflow, 8'h20);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        @(negedge clock);
        checkOutput("ovf_cleared", overflow, 8'h00);
        tick();

        // Capture on stream 1 lands on its own grant edge
        $display("[TB] same-edge grant and capture");
        doReset();
        din[1] = 110'h1;
        applyStimulus(8'h02);
        din[1] = 110'h2;
        applyStimulus(8'h02);
        @(negedge clock);
        checkOutput("same_hdr", tx_data, 8'hA1);
        checkOutput("same_pend", pending, 8'h02);
        checkOutput("same_no_ovf", overflow, 8'h00);
        tick();
        waitDone("same_first", 40);
        waitDone("same_second", 40);
        checkUnitPacket("same_old", 0, 8'hA1);
        checkLog("same_new_hdr", 15, 8'hA1);
        checkLog("same_new_tail", 29, 8'h08);
        checkOutput("same_ovf_end", overflow, 8'h00);

        // Reset while payload byte 6 is on the bus
        $display("[TB] reset mid payload");
        doReset();
        din[4] = 110'h1;
        applyStimulus(8'h10);
        repeat (8) tick();
        done_before = done_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abort_tx_valid", {7'b0, tx_valid}, 8'h00);
        checkOutput("abort_busy", {7'b0, busy}, 8'h00);
        checkOutput("abort_pending", pending, 8'h00);
        checkOutput("abort_done", {7'b0, packet_done}, 8'h00);
        tick();
        repeat (3) tick();
        checkOutput("abort_no_done", 8'(done_count - done_before), 8'd0);
        tx_log.delete();
        din[6] = 110'h1;
        applyStimulus(8'h40);
        waitDone("after_abort", 40);
        checkUnitPacket("after_abort", 0, 8'hA6);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ion_stream_scheduler.md
Name: ion_stream_scheduler

Overview:
Sits between the 8-stream ion sensor simulator and the Bluetooth UART transmitter. It captures 110-bit packets from any of the 8 streams when they are presented, and arbitrates among pending streams round-robin. It serialises one packet at a time into a header byte plus 14 payload bytes over a valid/ready byte interface.

Parameters:
HEADER_TAG, 5'b10100, upper 5 bits of the header byte; low 3 bits carry the stream ID.
PAYLOAD_BYTES, 14, number of payload bytes per packet: 110 bits = 13 full bytes + 6 bits zero-padded.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising edge
capture  in  1  data_in*/ready_in valid this cycle; mirrors the simulator's Read_Packet phase
ready_in  in  8  bit k set = stream k presents a new packet this cycle
data_in0..data_in7  in  110 each  packet data of streams 0..7
clear_overflow  in  1  one-cycle pulse; clears all overflow bits
tx_ready  in  1  transmitter accepts tx_data this cycle
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid
busy  out  1  high in every state except IDLE
current_stream  out  3  stream being sent; holds its last value when idle
pending  out  8  bit k = stream k holds an unsent packet
overflow  out  8  sticky; stream k packet overwritten before it was sent
packet_done  out  1  one-cycle pulse after the last payload byte is accepted

Behaviour:
- Reset: state=IDLE; rr_ptr=0; pending, overflow, current_stream, byte_cnt=0; tx_valid=0; tx_data=0; packet_done=0; busy=0; holding and shift registers cleared.
- Capture: at an edge where capture && ready_in[k]:
  - hold_k <= data_in_k and pending[k] <= 1.
  - If pending[k] was already 1 and stream k is not granted that same edge, hold_k is overwritten and overflow[k] <= 1.
- Overflow clear: clear_overflow clears all overflow bits. If it coincides with a new overflow event, the set wins.
- States: IDLE, HEADER, PAYLOAD, DONE.
- IDLE:
  - If pending != 0, grant = first set bit searching from rr_ptr upward, mod 8.
  - On that edge: current_stream <= grant; shift <= hold_grant; pending[grant] <= 0; rr_ptr <= grant+1 mod 8; go to HEADER.
  - Capture on the same stream at the grant edge: shift takes the old hold value, hold takes the new data, pending stays 1, no overflow.
  - The first header byte appears 1 cycle after pending is visible in IDLE, i.e. 2 edges after the capture edge.
- HEADER:
  - tx_valid=1, tx_data={HEADER_TAG, current_stream}.
  - On tx_valid && tx_ready: byte_cnt <= 0, go to PAYLOAD.
- PAYLOAD:
  - tx_valid=1. Data is sent MSB first: tx_data=shift[109:102] for byte_cnt 0..12, and {shift[109:104], 2'b00} for byte_cnt 13.
  - On each handshake: shift <<= 8 and byte_cnt++.
  - The handshake at byte_cnt==PAYLOAD_BYTES-1 goes to DONE.
- DONE: tx_valid=0, packet_done=1 for one cycle, then go to IDLE. Minimum packet spacing is therefore 1 DONE + 1 IDLE cycle.
- Handshake rules:
  - tx_valid and tx_data remain stable until tx_ready is seen; tx_valid never drops mid-byte.
  - tx_ready while tx_valid=0 is ignored.
  - Stalls are unlimited.
- Captures continue to be accepted in every state.
- Reset mid-packet: the transfer is aborted and tx_valid drops on the next cycle; no partial completion and no packet_done.
- byte_cnt is 4 bits. rr_ptr is 3 bits and wraps from 7 to 0.

Test Plan:
- Single packet: after reset, capture with ready_in=8'h04 and data_in2=110'h1 → bytes A2, then 13×00, then 04 (the 6-bit tail 000001 shifted into {000001,00}); packet_done pulses once; pending=0.
- Round-robin: capture ready_in=8'h81 with tx_ready=1 → stream 0 is sent, then stream 7 (headers A0, A7). Then capture ready_in=8'h81 again → order 0 then 7 again, since rr_ptr wrapped to 0.
- Backpressure: hold tx_ready=0 for 5 cycles in the middle of the payload → tx_data/tx_valid unchanged throughout; the byte sequence is identical to the no-stall run.
- Overflow: while stream 3 is being sent, capture stream 5 twice → overflow=8'h20, and the second data is what gets transmitted. Pulse clear_overflow → overflow=0.
- Same-edge grant and capture: stream 1 is pending in IDLE and a new capture for stream 1 lands on the grant edge → the old data is sent first, the new data is sent next, overflow[1]=0.
- Reset mid-PAYLOAD at byte 6 → the next cycle shows tx_valid=0, busy=0, pending=0 and no packet_done; a subsequent capture is sent normally.
